// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the IF stage: saturating-counter pattern table indexed bimodally or
// gshare-style, plus a direct-mapped tagged BTB. Lookup is combinational from registered state only.
module branch_predictor #(
    parameter  int XLEN      = 32,
    parameter  int ENTRIES   = 64,
    parameter  int CTR_BITS  = 2,
    parameter  int HIST_BITS = 0,
    localparam int IDX       = $clog2(ENTRIES),
    localparam int HW        = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lu_valid,
    input  logic [XLEN-1:0] lu_pc,
    output logic            lu_hit,
    output logic            lu_taken,
    output logic [XLEN-1:0] lu_target,
    output logic [HW-1:0]   lu_hist,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_is_jump,
    input  logic [XLEN-1:0] upd_target,
    input  logic [HW-1:0]   upd_hist,
    input  logic            upd_mispredict
);

    localparam int TAGW = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] r_pht       [ENTRIES];
    logic [ENTRIES-1:0]  r_btbValid;
    logic [TAGW-1:0]     r_btbTag    [ENTRIES];
    logic [XLEN-1:0]     r_btbTarget [ENTRIES];
    logic [HW-1:0]       r_ghr;

    logic [IDX-1:0]      w_luBidx;
    logic [IDX-1:0]      w_updBidx;
    logic [IDX-1:0]      w_luPidx;
    logic [IDX-1:0]      w_updPidx;
    logic [TAGW-1:0]     w_luTag;
    logic [TAGW-1:0]     w_updTag;
    logic                w_luHit;
    logic                w_luTaken;
    logic [CTR_BITS-1:0] w_ctrCur;
    logic [CTR_BITS-1:0] w_ctrNext;
    logic [HW-1:0]       w_ghrShift;
    logic [HW-1:0]       w_ghrRepair;
    logic                w_unused;

    assign w_luBidx  = lu_pc[IDX+1:2];
    assign w_updBidx = upd_pc[IDX+1:2];
    assign w_luTag   = lu_pc[XLEN-1:IDX+2];
    assign w_updTag  = upd_pc[XLEN-1:IDX+2];

    // History only perturbs the PHT index; the BTB is always addressed by the plain PC bits.
    generate
        if (HIST_BITS == 0) begin : gBimodal
            assign w_luPidx  = w_luBidx;
            assign w_updPidx = w_updBidx;
        end else begin : gGshare
            assign w_luPidx  = w_luBidx ^ IDX'(r_ghr);
            assign w_updPidx = w_updBidx ^ IDX'(upd_hist);
        end

        if (HW == 1) begin : gHistOne
            assign w_ghrShift  = w_luTaken;
            assign w_ghrRepair = upd_taken;
        end else begin : gHistWide
            assign w_ghrShift  = {r_ghr[HW-2:0], w_luTaken};
            assign w_ghrRepair = {upd_hist[HW-2:0], upd_taken};
        end
    endgenerate

    assign w_luHit   = r_btbValid[w_luBidx] && (r_btbTag[w_luBidx] == w_luTag);
    assign w_luTaken = w_luHit && r_pht[w_luPidx][CTR_BITS-1];

    assign lu_hit    = w_luHit;
    assign lu_taken  = w_luTaken;
    assign lu_target = w_luTaken ? r_btbTarget[w_luBidx] : lu_pc + XLEN'(4);
    assign lu_hist   = r_ghr;

    assign w_ctrCur = r_pht[w_updPidx];

    always_comb begin
        w_ctrNext = w_ctrCur;
        if (upd_is_jump) begin
            w_ctrNext = CTR_MAX;
        end else if (upd_taken) begin
            if (w_ctrCur != CTR_MAX) w_ctrNext = w_ctrCur + 1'b1;
        end else begin
            if (w_ctrCur != '0) w_ctrNext = w_ctrCur - 1'b1;
        end
    end

    // A mispredict repair takes priority over the speculative shift from this cycle's lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btbValid <= '0;
            r_ghr      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else begin
            if (upd_valid) begin
                r_pht[w_updPidx] <= w_ctrNext;
                if (upd_taken) r_btbValid[w_updBidx] <= 1'b1;
            end
            if (HIST_BITS > 0) begin
                if (upd_valid && upd_mispredict) begin
                    r_ghr <= w_ghrRepair;
                end else if (lu_valid) begin
                    r_ghr <= w_ghrShift;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            r_btbTag[w_updBidx]    <= w_updTag;
            r_btbTarget[w_updBidx] <= upd_target;
        end
    end

    assign w_unused = ^{lu_pc[1:0], upd_pc[1:0], upd_hist, upd_mispredict};

endmodule
